// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the integer MAC systolic array (PE, array top, edge feeders).
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } skew_state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_N          = 4;
    localparam int DEFAULT_K_WIDTH    = 8;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand-feeder bus: pass control, input vector handshake and skewed edge output.
// stall_cnt exists only when SKEW_FEEDER_STALL_CNT_EN is defined.
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N,
  parameter int K_WIDTH    = DEFAULT_K_WIDTH
);
  logic                    start;
  logic [K_WIDTH-1:0]      k_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_data;
  logic [N*DATA_WIDTH-1:0] out_data;
  logic                    busy;
  logic                    done;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [K_WIDTH-1:0]      stall_cnt;
`endif

  modport master (
    output start, k_len, in_valid, in_data,
    input  in_ready, out_data, busy, done
`ifdef SKEW_FEEDER_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, k_len, in_valid, in_data,
    output in_ready, out_data, busy, done
`ifdef SKEW_FEEDER_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/skew_lane.sv
// One lane of the feeder skew: a DEPTH-register shift chain, data passed through unmodified.
module skew_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);
  logic signed [DATA_WIDTH-1:0] chain [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < DEPTH; j++) chain[j] <= '0;
    end else begin
      chain[0] <= din;
      for (int j = 1; j < DEPTH; j++) chain[j] <= chain[j-1];
    end
  end

  assign dout = chain[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// Systolic-array edge feeder: frames a K-vector pass and skews lane i by i+1 cycles.
// Optional stall counter on the bus when SKEW_FEEDER_STALL_CNT_EN is defined.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N,
  parameter int K_WIDTH    = DEFAULT_K_WIDTH
) (
  input logic                 clk,
  input logic                 rstn,
  systolic_skew_feeder_if.slave bus
);
  localparam int FCW   = (N > 1) ? $clog2(N) : 1;
  localparam bit MULTI = (N > 1);

  skew_state_t             state;
  logic [K_WIDTH-1:0]      remaining;
  logic [FCW-1:0]          flush_cnt;
  logic                    in_ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    accept;
  logic                    start_ok;
  logic [N*DATA_WIDTH-1:0] inj;
  logic [N*DATA_WIDTH-1:0] out_vec;

  assign accept   = (state == LOAD) && bus.in_valid;
  assign start_ok = (state == IDLE) && bus.start && (bus.k_len != '0);
  // Anything other than an accepted vector enters the skew as zeros.
  assign inj      = accept ? bus.in_data : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      remaining  <= '0;
      flush_cnt  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            remaining  <= bus.k_len;
            state      <= LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            remaining <= remaining - K_WIDTH'(1);
            if (remaining == K_WIDTH'(1)) begin
              in_ready_q <= 1'b0;
              flush_cnt  <= '0;
              if (MULTI) begin
                state <= FLUSH;
              end else begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          // N-1 flush cycles: the last vector then sits in lane N-1's final register.
          if (flush_cnt == FCW'(N - 2)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FCW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [K_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state == LOAD) && !bus.in_valid && (stall_q != '1)) begin
      stall_q <= stall_q + K_WIDTH'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (i + 1)
    ) u_lane (
      .clk (clk),
      .rstn(rstn),
      .din (inj[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout(out_vec[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.out_data = out_vec;
  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Edge feeder for the integer MAC systolic array. Accepts one N-lane operand vector per handshake and drives the array's west edge (row operands) or north edge (column operands) with lane i delayed i+1 cycles, producing the diagonal wavefront the PEs need. It frames one K-length accumulation pass:

- load K vectors;
- flush zeros until the last vector has fully entered the array;
- pulse `done`.

Two instances, one per edge, are driven from a common `start` and common valid/stall so their wavefronts stay aligned.

## Interface
- `DATA_WIDTH`, 16, signed operand width per lane; matches the PE operand width.
- `N`, 4, number of lanes (array rows or columns), N ≥ 1.
- `K_WIDTH`, 8, width of the pass-length field; maximum pass is 2^K_WIDTH−1 vectors.

- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `k_len`  in  K_WIDTH  vectors in this pass; sampled with `start`.
- `in_valid`  in  1  `in_data` holds a vector.
- `in_ready`  out  1  feeder accepts a vector this cycle.
- `in_data`  in  N*DATA_WIDTH  lane i = `in_data[i*DATA_WIDTH +: DATA_WIDTH]`.
- `out_data`  out  N*DATA_WIDTH  lane i drives the edge PE of row/column i.
- `busy`  out  1  high in LOAD, FLUSH, DONE.
- `done`  out  1  one-cycle pulse at end of pass.
- `stall_cnt`  out  K_WIDTH  only with `SKEW_FEEDER_STALL_CNT_EN`.

## Operation
- **States:** IDLE, LOAD, FLUSH, DONE.
- **IDLE:**
  - `in_ready`=0; zero vectors are injected into the skew.
  - `start`=1 with `k_len`≠0: latch `k_len` into `remaining`, go to LOAD.
  - `start` with `k_len`=0 is ignored.
- **LOAD:**
  - `in_ready`=1.
  - On `in_valid`: the vector enters the skew and `remaining` decrements.
  - On `in_valid`=0: a zero vector is injected (a bubble) and `remaining` is unchanged. The bubble adds 0 to every PE accumulator.
  - When the accepted vector is the last one (`remaining`=1): go to FLUSH if N>1, else go to DONE.
- **FLUSH:**
  - `in_ready`=0; zeros are injected.
  - A counter runs for exactly N−1 cycles, then the state goes to DONE.
- **DONE:** `done`=1 for one cycle, zeros are injected, then the state returns to IDLE.
- **Ignored inputs:** `start` is ignored outside IDLE. `in_valid` outside LOAD is ignored and never consumed.
- **Skew:**
  - Lane i is a shift chain of i+1 registers, N(N+1)/2 registers in total, all DATA_WIDTH signed.
  - Data is passed unmodified; there is no arithmetic on operands.
- **Reset:** asynchronous, at any time including mid-pass.
  - State → IDLE; all skew registers, `remaining`, the flush counter and `stall_cnt` → 0.
  - `out_data`=0, `in_ready`=0, `busy`=0, `done`=0.
  - Remaining data of the interrupted pass is discarded.

## Timing
- **Handshake:** a transfer occurs on a rising edge with `in_valid`=1 and `in_ready`=1. `in_ready` is a registered function of state only, never of `in_valid`.
- **Latency:** a vector accepted at edge E appears on lane i after edge E+i. Lane 0 is visible in the cycle after acceptance.
- **First cycle after `start`:** LOAD is entered at the edge sampling `start`, so `in_ready` is high the cycle after `start`.
- **Pass length:** with no stalls, a pass of K vectors occupies K LOAD cycles, N−1 FLUSH cycles and 1 DONE cycle.
- **Alignment with `done`:** during the DONE cycle, lane N−1 presents the last vector's element. Lanes 0..N−2 already present zeros.
- **Back-to-back passes:** `start` is accepted in the cycle after DONE, giving a minimum 1-cycle IDLE gap between passes.

## Configuration
- **`SKEW_FEEDER_STALL_CNT_EN` defined:**
  - `stall_cnt` counts LOAD cycles with `in_valid`=0.
  - It clears on `start` acceptance and saturates at all-ones.
  - It holds its value after `done` until the next `start`.
- **`SKEW_FEEDER_STALL_CNT_EN` undefined:** the `stall_cnt` port and its counter are absent; all other behaviour is identical.

## Structure
- **Shared package `systolic_pkg`:**
  - state enum `skew_state_t` {IDLE, LOAD, FLUSH, DONE};
  - default `DATA_WIDTH`/`N` constants, shared with the PE and array top.
- **Sub-module `skew_lane`:**
  - parameters `DATA_WIDTH` and `DEPTH`;
  - a DEPTH-register shift chain with asynchronous active-low reset to 0;
  - instantiated N times with DEPTH=i+1.
- **Top:** the FSM, `remaining`, the flush counter and the zero-injection mux stay in the top module.

## Test plan
- **Reset values:** `rstn` low mid-LOAD with nonzero data in the skew → all outputs 0 immediately; after release, IDLE and `in_ready`=0.
- **Basic pass:** N=4, `start` with `k_len`=3, vectors {1,2,3,4},{5,6,7,8},{9,10,11,12} back-to-back.
  - Lane 3 shows 4,8,12 on cycles 4,5,6 after the first acceptance.
  - `done` high on cycle 6; lane 3 = 12 in that cycle.
- **Stall:** `k_len`=2 with `in_valid` low for 2 cycles between vectors.
  - Every lane shows the 2-cycle zero gap between the two vectors.
  - `done` is 2 cycles later than without the stall.
  - `stall_cnt`=2 when the macro is defined.
- **Ignored starts:** `start` with `k_len`=0 → stays IDLE, no `done`. `start` pulsed mid-LOAD → no effect on `remaining`.
- **N=1 edge case:** `k_len`=1 → LOAD→DONE with no FLUSH; `done` in the cycle after acceptance, with `out_data` = the vector.
- **Back-to-back passes:** `start` in the cycle after `done` → the second pass runs with correct skew and no residue from the first.
